// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM stage: decode, slt fix-up, branch resolution, overflow trap
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with registered in_ready; default is one register.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  input  logic [31:0] store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  input  logic        flush,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        ovf_exc,
  output logic [31:0] exc_pc
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } entry_t;

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [4:0]  d_dest;
  logic        d_wr, d_rd, d_wrm, d_slt, d_ovf_op, d_beq, d_bne;
  logic        ovf, taken;
  logic [31:0] target;
  entry_t      new_entry;
  entry_t      head;
  logic        head_v;
  logic        accept, deliver;
  logic        unused_rs;

  assign opcode    = instruction[31:26];
  assign func      = instruction[5:0];
  assign imm       = instruction[15:0];
  assign unused_rs = ^instruction[25:21];

  always_comb begin
    d_dest   = 5'd0;
    d_wr     = 1'b0;
    d_rd     = 1'b0;
    d_wrm    = 1'b0;
    d_slt    = 1'b0;
    d_ovf_op = 1'b0;
    d_beq    = 1'b0;
    d_bne    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_dest   = instruction[15:11];
        d_wr     = 1'b1;
        d_slt    = (func == FN_SLT) || (func == FN_SLTU);
        d_ovf_op = (func == FN_ADD) || (func == FN_SUB);
      end
      OP_ADDI: begin
        d_dest   = instruction[20:16];
        d_wr     = 1'b1;
        d_ovf_op = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d_dest = instruction[20:16];
        d_wr   = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        d_dest = instruction[20:16];
        d_wr   = 1'b1;
        d_slt  = 1'b1;
      end
      OP_LW: begin
        d_dest = instruction[20:16];
        d_wr   = 1'b1;
        d_rd   = 1'b1;
      end
      OP_SW:   d_wrm = 1'b1;
      OP_BEQ:  d_beq = 1'b1;
      OP_BNE:  d_bne = 1'b1;
      default: ;
    endcase
  end

  assign ovf    = d_ovf_op && alu_flags[0];
  assign taken  = (d_beq && alu_flags[2]) || (d_bne && !alu_flags[2]);
  assign target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};

  // A trapped add/sub still travels down the pipe, but must not retire a write.
  assign new_entry.result     = d_slt ? {31'b0, alu_flags[1]} : alu_result;
  assign new_entry.store_data = store_data;
  assign new_entry.dest       = d_dest;
  assign new_entry.reg_write  = d_wr && (d_dest != 5'd0) && !ovf;
  assign new_entry.mem_read   = d_rd;
  assign new_entry.mem_write  = d_wrm;

  assign accept  = in_valid && in_ready && !flush;
  assign deliver = head_v && out_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid;
  logic   skid_v;
  logic   ready_q;

  assign in_ready = ready_q;

  // head is always the older entry; skid only fills while head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      head_v  <= 1'b0;
      skid    <= '0;
      skid_v  <= 1'b0;
      ready_q <= 1'b0;
    end else if (flush) begin
      head_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (deliver && skid_v) begin
      head    <= skid;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (deliver || !head_v) begin
      head_v  <= accept;
      if (accept) head <= new_entry;
      ready_q <= 1'b1;
    end else if (accept) begin
      skid    <= new_entry;
      skid_v  <= 1'b1;
      ready_q <= 1'b0;
    end
  end
`else
  assign in_ready = !head_v || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      head_v <= 1'b0;
    end else if (flush) begin
      head_v <= 1'b0;
    end else if (accept) begin
      head   <= new_entry;
      head_v <= 1'b1;
    end else if (deliver) begin
      head_v <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken  <= 1'b0;
      branch_target <= 32'd0;
      ovf_exc       <= 1'b0;
      exc_pc        <= 32'd0;
    end else begin
      branch_taken <= accept && taken;
      ovf_exc      <= accept && ovf;
      if (accept && taken) branch_target <= target;
      if (accept && ovf)   exc_pc        <= pc;
    end
  end

  assign out_valid      = head_v;
  assign out_result     = head.result;
  assign out_store_data = head.store_data;
  assign out_dest       = head.dest;
  assign out_reg_write  = head.reg_write;
  assign out_mem_read   = head.mem_read;
  assign out_mem_write  = head.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed-vector bench for ex_mem_stage (either EX_MEM_SKID_EN build)
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic [31:0] store_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ovf_exc;
  logic [31:0] exc_pc;

  int nvec;
  int nmis;

`ifdef EX_MEM_SKID_EN
  localparam logic RDY_IN_RESET = 1'b0;
`else
  localparam logic RDY_IN_RESET = 1'b1;
`endif

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .alu_result(alu_result),
    .alu_flags(alu_flags), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_dest(out_dest), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .ovf_exc(ovf_exc), .exc_pc(exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] im);
    return {op, 5'd1, rt, im};
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] res,
                      input logic [2:0] fl, input logic [31:0] sd);
    instruction = ins;
    pc          = p;
    alu_result  = res;
    alu_flags   = fl;
    store_data  = sd;
    in_valid    = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    nvec = 0; nmis = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    instruction = '0; pc = '0; alu_result = '0; alu_flags = '0; store_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_btgt", branch_target, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_in_ready", in_ready, RDY_IN_RESET);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // add overflow
    send(rtype(5'd5, 6'h20), 32'h100, 32'h8000_0000, 3'b001, 32'h0);
    step();
    chk("add_ovf_valid", out_valid, 1);
    chk("add_ovf_regwr", out_reg_write, 0);
    chk("add_ovf_dest", out_dest, 5);
    chk("add_ovf_result", out_result, 32'h8000_0000);
    chk("add_ovf_pulse", ovf_exc, 1);
    chk("add_ovf_excpc", exc_pc, 32'h100);
    tick();
    chk("add_ovf_pulse_end", ovf_exc, 0);
    chk("add_ovf_excpc_hold", exc_pc, 32'h100);
    chk("add_ovf_drained", out_valid, 0);

    // slt rd=3
    send(rtype(5'd3, 6'h2A), 32'h10, 32'hFFFF_FFFE, 3'b010, 32'h0);
    step();
    chk("slt_result", out_result, 32'h1);
    chk("slt_dest", out_dest, 3);
    chk("slt_regwr", out_reg_write, 1);
    chk("slt_no_ovf", ovf_exc, 0);

    // beq taken, backward offset lands on itself
    send(itype(6'h04, 5'd0, 16'hFFFF), 32'h40, 32'h0, 3'b100, 32'h0);
    step();
    chk("beq_taken", branch_taken, 1);
    chk("beq_target", branch_target, 32'h40);
    chk("beq_regwr", out_reg_write, 0);
    tick();
    chk("beq_pulse_end", branch_taken, 0);
    chk("beq_target_hold", branch_target, 32'h40);

    send(itype(6'h05, 5'd0, 16'hFFFF), 32'h40, 32'h0, 3'b100, 32'h0);
    step();
    chk("bne_not_taken", branch_taken, 0);

    send(itype(6'h05, 5'd0, 16'h0010), 32'h200, 32'h0, 3'b000, 32'h0);
    step();
    chk("bne_taken", branch_taken, 1);
    chk("bne_target", branch_target, 32'h244);

    send(itype(6'h2B, 5'd7, 16'h0008), 32'h300, 32'h1008, 3'b000, 32'hDEAD_BEEF);
    step();
    chk("sw_memwr", out_mem_write, 1);
    chk("sw_memrd", out_mem_read, 0);
    chk("sw_regwr", out_reg_write, 0);
    chk("sw_data", out_store_data, 32'hDEAD_BEEF);
    chk("sw_result", out_result, 32'h1008);

    send(itype(6'h08, 5'd0, 16'h0001), 32'h380, 32'h5, 3'b000, 32'h0);
    step();
    chk("addi_r0_regwr", out_reg_write, 0);

    send(itype(6'h08, 5'd9, 16'h0001), 32'h400, 32'h8000_0000, 3'b001, 32'h0);
    step();
    chk("addi_ovf_pulse", ovf_exc, 1);
    chk("addi_ovf_regwr", out_reg_write, 0);
    chk("addi_ovf_dest", out_dest, 9);
    chk("addi_ovf_excpc", exc_pc, 32'h400);

    send(itype(6'h09, 5'd9, 16'h0001), 32'h404, 32'h8000_0000, 3'b001, 32'h0);
    step();
    chk("addiu_no_trap", ovf_exc, 0);
    chk("addiu_regwr", out_reg_write, 1);
    chk("addiu_excpc_hold", exc_pc, 32'h400);

    send(itype(6'h3F, 5'd9, 16'h0001), 32'h408, 32'h7, 3'b000, 32'h0);
    step();
    chk("unk_regwr", out_reg_write, 0);
    chk("unk_memrd", out_mem_read, 0);
    tick();

    // three lw under back-pressure
    out_ready = 1'b0;
`ifdef EX_MEM_SKID_EN
    send(itype(6'h23, 5'd1, 16'h0), 32'h500, 32'hA0, 3'b000, 32'h0);
    tick();
    chk("bp_rdy_one", in_ready, 1);
    send(itype(6'h23, 5'd2, 16'h0), 32'h504, 32'hB0, 3'b000, 32'h0);
    tick();
    chk("bp_rdy_full", in_ready, 0);
    chk("bp_head_a", out_result, 32'hA0);
    send(itype(6'h23, 5'd3, 16'h0), 32'h508, 32'hC0, 3'b000, 32'h0);
    tick();
    chk("bp_rdy_still_full", in_ready, 0);
    chk("bp_head_a_hold", out_result, 32'hA0);
    chk("bp_dest_a", out_dest, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", out_result, 32'hB0);
    chk("bp_dest_b", out_dest, 2);
    chk("bp_memrd_b", out_mem_read, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", out_result, 32'hC0);
    chk("bp_dest_c", out_dest, 3);
    chk("bp_memrd_c", out_mem_read, 1);
    tick();
    chk("bp_drained", out_valid, 0);
`else
    send(itype(6'h23, 5'd1, 16'h0), 32'h500, 32'hA0, 3'b000, 32'h0);
    tick();
    chk("bp_rdy_full", in_ready, 0);
    chk("bp_valid_a", out_valid, 1);
    send(itype(6'h23, 5'd2, 16'h0), 32'h504, 32'hB0, 3'b000, 32'h0);
    tick();
    chk("bp_head_a_hold", out_result, 32'hA0);
    chk("bp_dest_a", out_dest, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", out_result, 32'hB0);
    chk("bp_dest_b", out_dest, 2);
    send(itype(6'h23, 5'd3, 16'h0), 32'h508, 32'hC0, 3'b000, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", out_result, 32'hC0);
    chk("bp_memrd_c", out_mem_read, 1);
    tick();
    chk("bp_drained", out_valid, 0);
`endif

    // flush with stored entries and a taken beq presented
    out_ready = 1'b0;
    send(itype(6'h23, 5'd1, 16'h0), 32'h600, 32'h11, 3'b000, 32'h0);
    tick();
`ifdef EX_MEM_SKID_EN
    send(itype(6'h23, 5'd2, 16'h0), 32'h604, 32'h22, 3'b000, 32'h0);
    tick();
`endif
    chk("fl_pre_valid", out_valid, 1);
    send(itype(6'h04, 5'd0, 16'h0001), 32'h80, 32'h0, 3'b100, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_no_branch", branch_taken, 0);
    chk("fl_target_hold", branch_target, 32'h244);
    chk("fl_rdy", in_ready, 1);

    // flush drops an acceptable overflowing add
    send(rtype(5'd5, 6'h20), 32'h700, 32'h8000_0000, 3'b001, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_no_ovf", ovf_exc, 0);
    chk("fl_excpc_hold", exc_pc, 32'h400);
    chk("fl_add_dropped", out_valid, 0);

    // asynchronous reset mid-stream
    send(itype(6'h2B, 5'd7, 16'h0), 32'h800, 32'h1234, 3'b000, 32'hCAFE_F00D);
    step();
    chk("ar_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_result", out_result, 0);
    chk("ar_sdata", out_store_data, 0);
    chk("ar_memwr", out_mem_write, 0);
    chk("ar_btgt", branch_target, 0);
    chk("ar_excpc", exc_pc, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ar_rdy_after", in_ready, 1);
    chk("ar_valid_after", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock), rst_n (input, 1, asynchronous active-low reset).
REQ-002 The module SHALL have these upstream (ALU-side) inputs:
- in_valid (1): ALU result valid.
- in_ready (output, 1): stage can accept.
- instruction (32): instruction executed by the ALU.
- pc (32): address of that instruction.
- alu_result (32): ALU result.
- alu_flags (3): [2] zero, [1] negative, [0] overflow.
- store_data (32): rt register value, used for sw.
REQ-003 The module SHALL have these downstream (memory-side) ports:
- out_valid (output, 1).
- out_ready (input, 1).
- out_result (output, 32).
- out_store_data (output, 32).
- out_dest (output, 5).
- out_reg_write (output, 1).
- out_mem_read (output, 1).
- out_mem_write (output, 1).
REQ-004 The module SHALL have these control ports:
- flush (input, 1): synchronous pipeline flush.
- branch_taken (output, 1).
- branch_target (output, 32).
- ovf_exc (output, 1).
- exc_pc (output, 32).

Function
REQ-005 An entry SHALL be accepted on a rising clk edge when in_valid && in_ready && !flush.
REQ-006 An entry SHALL be delivered when out_valid && out_ready. out_* SHALL hold stable while out_valid && !out_ready.
REQ-007 Decode SHALL use opcode=instruction[31:26] and func=instruction[5:0]:
- Opcode 0: R-type, dest=instruction[15:11].
- addi/addiu/andi/ori/xori/slti/sltiu/lw: dest=instruction[20:16].
- beq/bne/sw: dest=0.
REQ-008 out_reg_write SHALL be 1 for R-type (all ALU funcs), the immediate ops and lw; 0 for beq/bne/sw and unrecognised opcodes. out_reg_write SHALL also be 0 if dest==0.
REQ-009 out_mem_read SHALL be 1 only for lw (opcode 100011). out_mem_write SHALL be 1 only for sw (opcode 101011).
REQ-010 For slt, sltu, slti and sltiu, out_result SHALL be {31'b0, alu_flags[1]}. For all other instructions, out_result SHALL be alu_result unchanged.
REQ-011 For add (func 100000), sub (100010) and addi (001000) with alu_flags[0]=1:
- The entry SHALL be accepted with out_reg_write=0.
- ovf_exc SHALL pulse high for exactly one cycle after acceptance.
- exc_pc SHALL load pc and hold until the next overflow.
REQ-012 Branch resolution:
- beq is taken iff alu_flags[2]=1; bne is taken iff alu_flags[2]=0.
- On acceptance, branch_taken SHALL pulse one cycle.
- branch_target SHALL be pc+4+(sign-extended instruction[15:0]<<2), modulo 2^32.
- branch_target SHALL hold its last value otherwise.
REQ-013 The branch_taken and ovf_exc pulses SHALL occur in the cycle after acceptance, independent of out_ready.
REQ-014 Flush:
- flush=1 SHALL invalidate all stored entries at the next edge.
- flush=1 SHALL drop the same-cycle input.
- No branch_taken or ovf_exc pulse SHALL be produced for a dropped input.
- flush SHALL take priority over simultaneous accept and deliver.
REQ-015 Simultaneous accept and deliver in one cycle SHALL preserve order and lose no entry.

Reset
REQ-016 While rst_n=0, the following outputs SHALL be 0 and all stored entries invalid:
- out_valid, out_result, out_store_data, out_dest, out_reg_write, out_mem_read, out_mem_write.
- branch_taken, branch_target, ovf_exc, exc_pc.
- in_ready (skid variant).
REQ-017 Reset assertion mid-transfer SHALL discard in-flight entries immediately, without waiting for clk.
REQ-018 After reset deassertion, in_ready SHALL be 1 on the first clk edge.

Configuration
REQ-019 Macro EX_MEM_SKID_EN defined:
- The stage SHALL be a 2-entry skid buffer.
- in_ready SHALL be a register output, equal to !(both entries full).
- Full throughput SHALL be sustained with out_ready toggling.
REQ-020 Macro EX_MEM_SKID_EN undefined:
- The stage SHALL be a single register.
- in_ready SHALL be combinational: !out_valid || out_ready.
REQ-021 Latency from accept to out_valid SHALL be 1 cycle in both variants.

Verification
REQ-022 add, pc=0x100, alu_result=0x80000000, flags=001, out_ready=1 -> next cycle:
- out_valid=1, out_reg_write=0.
- ovf_exc pulses one cycle.
- exc_pc=0x100.
REQ-023 beq, pc=0x40, imm=0xFFFF, flags=100 -> branch_taken pulses one cycle, branch_target=0x40.
REQ-023a bne with the same values -> no pulse.
REQ-024 slt rd=3, alu_result=0xFFFFFFFE, flags=010 -> out_result=0x00000001, out_dest=3, out_reg_write=1.
REQ-025 Skid build, out_ready=0, three back-to-back lw:
- 2 entries accepted, then in_ready=0.
- Raising out_ready delivers all three in order, with out_mem_read=1.
REQ-026 flush asserted with in_valid=1 (beq taken) and 2 entries stored -> next cycle out_valid=0 and no branch_taken pulse.
REQ-027 rst_n asserted low mid-stream while out_valid=1 -> all outputs 0 asynchronously; in_ready=1 after release.
